dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Target-side model of the CPU data-memory interface. It services the core's level-held read/write requests and drives ready and read data back to the core.
- Backed by an on-chip byte-writable synchronous RAM, with a parameterised and runtime-configurable number of wait states.
- Does byte-lane alignment, address-range and misalignment checking, and error reporting.
- Sits between the core's data-memory port and the FPGA BRAM. It also serves as the bench's memory model.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width. Fixed at 32; 4 byte lanes.
- DEPTH_WORDS, 4096, RAM depth in 32-bit words. Must be a power of 2.
- BASE_ADDR, 32'h0000_0000, first byte address served. Must be aligned to 4*DEPTH_WORDS.
- WAIT_STATES, 1, fixed wait cycles added to every access (0..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- dmem_addr  in  ADDR_WIDTH  byte address, held stable while ready=0
- dmem_write_data  in  DATA_WIDTH  store data, right-justified
- dmem_read  in  1  read request, level, held until acknowledged
- dmem_write  in  1  write request, level, held until acknowledged
- dmem_byte_enable  in  4  size mask, unshifted: 1=byte, 3=half, F=word
- dmem_read_data  out  DATA_WIDTH  load data, right-justified, registered
- dmem_ready  out  1  0 = core must stall
- cfg_extra_wait  in  4  additional wait cycles, sampled at acceptance
- err_pulse  out  1  one-cycle pulse on an errored access, coincident with ack
- err_addr  out  ADDR_WIDTH  address of the last errored access
- err_code  out  2  0 none, 1 out of range, 2 misaligned, 3 read and write both asserted
- err_count  out  16  saturating error count

Behaviour:
- Reset: state=IDLE; dmem_read_data=0, err_pulse=0, err_addr=0, err_code=0, err_count=0, wait counter=0. RAM contents are not cleared.
- req = dmem_read | dmem_write.
- dmem_ready is combinational: (state==IDLE && !req) || state==RESP.
- States:
  - IDLE: if req, latch addr/data/enable/type and load wcnt = WAIT_STATES + cfg_extra_wait (5-bit sum). Go to WAIT if wcnt>0, else ACCESS.
  - WAIT: decrement wcnt; at 1, go to ACCESS.
  - ACCESS: RAM read/write issued this cycle → RESP.
  - RESP: dmem_ready=1; dmem_read_data is valid; err_pulse is asserted if errored. Next state is IDLE unconditionally.
- Request-to-ack latency = WAIT_STATES + cfg_extra_wait + 2 cycles after the acceptance cycle.
- Back-to-back: a req seen in IDLE on the cycle after RESP is a new transaction, even with identical signals.
- Lanes:
  - off = addr[1:0]; be_eff = {4'b0, byte_enable} << off (8 bits).
  - Misaligned if be_eff[7:4] != 0.
  - Write lanes = be_eff[3:0]; write data = wdata << 8*off.
  - Read result = (word >> 8*off) masked to the size mask, zero-extended. Sign extension belongs to the core.
- Range: addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS → out of range. Word index = (addr - BASE_ADDR) >> 2.
- Error handling:
  - Errors are checked in priority: both asserted (3) > out of range (1) > misaligned (2).
  - An errored access still completes the handshake with the same latency.
  - No RAM write occurs; dmem_read_data=0.
  - err_addr and err_code are updated; err_count saturates at 16'hFFFF.
- Write path: write-only; dmem_read_data holds its previous value. The RAM is updated on the ACCESS→RESP edge.
- Request dropped mid-transaction (protocol violation): the access completes normally from latched values.
- Reset mid-transaction: immediately returns to IDLE; any pending write is discarded.

Optional Feature:
- DMEM_RESP_STATS_EN defined:
  - Adds outputs stat_reads[31:0], stat_writes[31:0] and stat_wait_cycles[31:0].
  - stat_reads and stat_writes count RESP cycles by type, including errored ones.
  - stat_wait_cycles counts cycles where req=1 && dmem_ready=0.
  - All wrap at 2^32 and reset to 0.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_resp_pkg:
  - state enum {IDLE, WAIT, ACCESS, RESP};
  - err_code enum;
  - byte-enable constants BE_BYTE/BE_HALF/BE_WORD;
  - function for lane shift/mask.
- Sub-module dmem_bram: single-port synchronous RAM with 4 byte-write enables and 1-cycle read latency. Inferable as BRAM.

Test Plan:
- WAIT_STATES=1, cfg=0: write word 0xDEADBEEF @0x10, then read @0x10 → ready low 3 cycles after acceptance, ack with read data 0xDEADBEEF; err_pulse=0.
- Byte store 0xAB @0x13, then word read @0x10 → 0xABADBEEF. Half read @0x12 (BE=3) → 0x0000ABAD.
- Half write @0x13 (BE=3) → err_code=2, err_pulse once, err_count=1; memory @0x10 unchanged on readback.
- Read @BASE_ADDR+4*DEPTH_WORDS → err_code=1, read data 0. Assert read and write together @0x20 → err_code=3, no write.
- cfg_extra_wait=7 changed mid-transaction to 0 → latency still 10 cycles. Next transaction → 3 cycles. Idle with no req → dmem_ready=1.
- rst_n pulse during WAIT of a write @0x40 → state IDLE, ready=1, readback @0x40 returns the old value. With DMEM_RESP_STATS_EN, after 3 reads and 2 writes: stat_reads=3, stat_writes=2.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared types and lane helpers for the data-memory responder
package dmem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_RANGE    = 2'd1,
    ERR_MISALIGN = 2'd2,
    ERR_BOTH     = 2'd3
  } err_t;

  localparam logic [3:0] BE_BYTE = 4'h1;
  localparam logic [3:0] BE_HALF = 4'h3;
  localparam logic [3:0] BE_WORD = 4'hF;

  // Lanes pushed past bit 3 mean the access straddles the word boundary.
  function automatic logic [7:0] be_shift(input logic [3:0] be, input logic [1:0] off);
    return {4'b0000, be} << off;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [3:0] be,
                                               input logic [1:0] off);
    logic [31:0] mask;
    case (be)
      BE_BYTE: mask = 32'h0000_00FF;
      BE_HALF: mask = 32'h0000_FFFF;
      BE_WORD: mask = 32'hFFFF_FFFF;
      default: for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
    endcase
    return (word >> {off, 3'b000}) & mask;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// rtl/dmem_bram.sv - single-port byte-writable synchronous RAM, one-cycle read latency
module dmem_bram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-memory target with wait states and error reporting
// Optional statistics counters: DMEM_RESP_STATS_EN.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_write_data,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [3:0]            dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] dmem_read_data,
  output logic                  dmem_ready,
  input  logic [3:0]            cfg_extra_wait,
  output logic                  err_pulse,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [1:0]            err_code,
  output logic [15:0]           err_count
`ifdef DMEM_RESP_STATS_EN
  ,
  output logic [31:0]           stat_reads,
  output logic [31:0]           stat_writes,
  output logic [31:0]           stat_wait_cycles
`endif
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  state_t                state;
  logic [4:0]            wcnt;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [31:0]           a_wdata;
  logic [3:0]            a_be;
  logic                  a_rd, a_wr;
  err_t                  err_code_q;

  logic                  req;
  logic [4:0]            nw;
  logic [ADDR_WIDTH:0]   offset;
  logic [7:0]            be_eff;
  err_t                  acc_err;
  logic [IDX_W-1:0]      ram_idx;
  logic [3:0]            ram_we;
  logic [31:0]           ram_q;

  assign req        = dmem_read | dmem_write;
  assign dmem_ready = ((state == IDLE) && !req) || (state == RESP);
  assign nw         = 5'(WAIT_STATES) + {1'b0, cfg_extra_wait};
  assign offset     = {1'b0, a_addr} - {1'b0, BASE_ADDR};
  assign be_eff     = be_shift(a_be, a_addr[1:0]);
  assign err_code   = err_code_q;

  always_comb begin
    acc_err = ERR_NONE;
    if (a_rd && a_wr)                         acc_err = ERR_BOTH;
    else if (offset[ADDR_WIDTH] || offset >= SPAN) acc_err = ERR_RANGE;
    else if (|be_eff[7:4])                    acc_err = ERR_MISALIGN;
  end

  // The RAM read is launched from the incoming address while idle so that the
  // word is already on ram_q during ACCESS and the load data can be registered.
  assign ram_idx = (state == IDLE) ? dmem_addr[IDX_W+1:2] : a_addr[IDX_W+1:2];
  assign ram_we  = (state == ACCESS && a_wr && acc_err == ERR_NONE) ? be_eff[3:0] : 4'b0000;

  dmem_bram #(.DEPTH(DEPTH_WORDS)) u_bram (
    .clk   (clk),
    .en    (1'b1),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (a_wdata << {a_addr[1:0], 3'b000}),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wcnt           <= '0;
      a_addr         <= '0;
      a_wdata        <= '0;
      a_be           <= '0;
      a_rd           <= 1'b0;
      a_wr           <= 1'b0;
      dmem_read_data <= '0;
      err_pulse      <= 1'b0;
      err_addr       <= '0;
      err_code_q     <= ERR_NONE;
      err_count      <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: if (req) begin
          a_addr  <= dmem_addr;
          a_wdata <= dmem_write_data;
          a_be    <= dmem_byte_enable;
          a_rd    <= dmem_read;
          a_wr    <= dmem_write;
          wcnt    <= nw;
          state   <= (nw != 5'd0) ? WAIT : ACCESS;
        end
        WAIT: begin
          wcnt <= wcnt - 5'd1;
          if (wcnt == 5'd1) state <= ACCESS;
        end
        ACCESS: begin
          state <= RESP;
          if (acc_err != ERR_NONE) begin
            err_pulse      <= 1'b1;
            err_addr       <= a_addr;
            err_code_q     <= acc_err;
            dmem_read_data <= '0;
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          end else if (a_rd) begin
            dmem_read_data <= lane_extract(ram_q, a_be, a_addr[1:0]);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_reads       <= '0;
      stat_writes      <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (state == RESP && a_rd) stat_reads  <= stat_reads + 32'd1;
      if (state == RESP && a_wr) stat_writes <= stat_writes + 32'd1;
      if (req && !dmem_ready)    stat_wait_cycles <= stat_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and random checks of dmem_responder against a byte-array model
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int WS    = 1;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_write_data = '0;
  logic        dmem_read = 1'b0;
  logic        dmem_write = 1'b0;
  logic [3:0]  dmem_byte_enable = 4'hF;
  logic [31:0] dmem_read_data;
  logic        dmem_ready;
  logic [3:0]  cfg_extra_wait = '0;
  logic        err_pulse;
  logic [31:0] err_addr;
  logic [1:0]  err_code;
  logic [15:0] err_count;
`ifdef DMEM_RESP_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_wait_cycles;
`endif

  dmem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
    .BASE_ADDR(32'h0), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dmem_addr(dmem_addr), .dmem_write_data(dmem_write_data),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
    .dmem_read_data(dmem_read_data), .dmem_ready(dmem_ready), .cfg_extra_wait(cfg_extra_wait),
    .err_pulse(err_pulse), .err_addr(err_addr), .err_code(err_code), .err_count(err_count)
`ifdef DMEM_RESP_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_wait_cycles(stat_wait_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:BYTES-1];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_rdata = '0;
  logic [1:0]  exp_code = '0;
  logic [31:0] exp_eaddr = '0;
  int          exp_count = 0;
  int          n_rd = 0, n_wr = 0, n_wait = 0;
  int          last_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [3:0] be);
    if (be == 4'h1) return 1;
    if (be == 4'h3) return 2;
    return 4;
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [3:0] cfg, input logic [3:0] cfg2);
    int cycles, sz;
    logic [1:0] code;
    @(negedge clk);
    dmem_read = rd; dmem_write = wr; dmem_addr = addr; dmem_byte_enable = be;
    dmem_write_data = wd; cfg_extra_wait = cfg;
    #1;
    cycles = 0;
    while (!dmem_ready && cycles < 64) begin
      @(negedge clk);
      cycles++;
      cfg_extra_wait = cfg2;
    end
    sz = size_of(be);
    if (rd && wr)                   code = 2'd3;
    else if (addr >= BYTES)         code = 2'd1;
    else if ((addr % 4) + sz > 4)   code = 2'd2;
    else                            code = 2'd0;
    if (code != 0) begin
      exp_rdata = '0; exp_code = code; exp_eaddr = addr;
      if (exp_count < 65535) exp_count++;
    end else if (rd) begin
      exp_rdata = '0;
      for (int k = 0; k < sz; k++) exp_rdata |= 32'(mem[addr + k]) << (8 * k);
    end else begin
      for (int k = 0; k < sz; k++) mem[addr + k] = wd[8*k +: 8];
    end
    n_rd += int'(rd); n_wr += int'(wr); n_wait += cycles;
    last_lat = cycles;
    check("latency", 32'(cycles), 32'(WS + cfg + 2));
    check("read_data", dmem_read_data, exp_rdata);
    check("err_pulse", 32'(err_pulse), 32'(code != 0));
    check("err_code", 32'(err_code), 32'(exp_code));
    check("err_addr", err_addr, exp_eaddr);
    check("err_count", 32'(err_count), 32'(exp_count));
    dmem_read = 1'b0; dmem_write = 1'b0;
  endtask

  initial begin
    logic [3:0] bes [3];
    bes[0] = 4'h1; bes[1] = 4'h3; bes[2] = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", 32'(dmem_ready), 32'd1);
    check("reset_rdata", dmem_read_data, 32'h0);
    check("reset_pulse", 32'(err_pulse), 32'd0);
    check("reset_code", 32'(err_code), 32'd0);
    check("reset_count", 32'(err_count), 32'd0);
    check("reset_eaddr", err_addr, 32'h0);
    rst_n = 1'b1;

    for (int w = 0; w < DEPTH; w++) access(0, 1, 32'(4 * w), 4'hF, $urandom, 4'd0, 4'd0);

    access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 4'd0, 4'd0);
    access(1, 0, 32'h10, 4'hF, 32'h0, 4'd0, 4'd0);
    check("word_rd", dmem_read_data, 32'hDEADBEEF);
    check("word_rd_lat", 32'(last_lat), 32'd3);
    access(0, 1, 32'h13, 4'h1, 32'h000000AB, 4'd0, 4'd0);
    access(1, 0, 32'h10, 4'hF, 32'h0, 4'd0, 4'd0);
    check("byte_merge", dmem_read_data, 32'hABADBEEF);
    access(1, 0, 32'h12, 4'h3, 32'h0, 4'd0, 4'd0);
    check("half_rd", dmem_read_data, 32'h0000ABAD);
    access(0, 1, 32'h13, 4'h3, 32'h00001234, 4'd0, 4'd0);
    check("misalign_code", 32'(err_code), 32'd2);
    @(negedge clk);
    check("pulse_once", 32'(err_pulse), 32'd0);
    access(1, 0, 32'h10, 4'hF, 32'h0, 4'd0, 4'd0);
    check("misalign_nowrite", dmem_read_data, 32'hABADBEEF);
    access(1, 0, 32'(BYTES), 4'hF, 32'h0, 4'd0, 4'd0);
    check("range_code", 32'(err_code), 32'd1);
    check("range_rdata", dmem_read_data, 32'h0);
    access(1, 1, 32'h20, 4'hF, 32'h55AA55AA, 4'd0, 4'd0);
    check("both_code", 32'(err_code), 32'd3);
    access(1, 0, 32'h20, 4'hF, 32'h0, 4'd0, 4'd0);
    access(1, 0, 32'h24, 4'hF, 32'h0, 4'd7, 4'd0);
    check("cfg7_lat", 32'(last_lat), 32'd10);
    access(1, 0, 32'h28, 4'hF, 32'h0, 4'd0, 4'd0);
    check("cfg0_lat", 32'(last_lat), 32'd3);
    @(negedge clk);
    check("idle_ready", 32'(dmem_ready), 32'd1);

    // Reset lands while a write to 0x40 is still in WAIT.
    @(negedge clk);
    dmem_write = 1'b1; dmem_read = 1'b0; dmem_addr = 32'h40; dmem_byte_enable = 4'hF;
    dmem_write_data = 32'h12345678; cfg_extra_wait = 4'd5;
    repeat (2) @(negedge clk);
    dmem_write = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(dmem_ready), 32'd1);
    check("rst_count", 32'(err_count), 32'd0);
    #2;
    rst_n = 1'b1;
    exp_rdata = '0; exp_code = '0; exp_eaddr = '0; exp_count = 0;
    n_rd = 0; n_wr = 0; n_wait = 0;
    access(1, 0, 32'h40, 4'hF, 32'h0, 4'd0, 4'd0);

    for (int i = 0; i < 60; i++) begin
      int r;
      logic [3:0] c;
      r = $urandom_range(0, 9);
      c = 4'($urandom_range(0, 3));
      access(r == 0 || (r >= 1 && r <= 5), r == 0 || r > 5, 32'($urandom_range(0, BYTES + 31)),
             bes[$urandom_range(0, 2)], $urandom, c, c);
    end

`ifdef DMEM_RESP_STATS_EN
    @(negedge clk);
    check("stat_reads", stat_reads, 32'(n_rd));
    check("stat_writes", stat_writes, 32'(n_wr));
    check("stat_wait", stat_wait_cycles, 32'(n_wait));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
